// File: rtl/led_pattern_pkg.sv
// LED pattern generator shared types and constants.
// Mode encoding, default geometry and an index-width helper.
package led_pattern_pkg;

  typedef enum logic [1:0] {
    ALL_ON   = 2'd0,
    WALK_LED = 2'd1,
    WALK_ROW = 2'd2,
    CHECKER  = 2'd3
  } pattern_mode_e;

  localparam int NB_DRIVERS_DEF = 30;
  localparam int NB_MUX_DEF     = 8;
  localparam int NB_LEDS_DEF    = 16;

  // Index width that never collapses to zero bits.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/led_pattern_gen_if.sv
// Link between the pattern source and driver_controller.
// master = pattern source, slave = driver controller.
interface led_pattern_gen_if #(
  parameter int NB_DRIVERS = led_pattern_pkg::NB_DRIVERS_DEF,
  parameter int NB_MUX     = led_pattern_pkg::NB_MUX_DEF,
  parameter int NB_LEDS    = led_pattern_pkg::NB_LEDS_DEF
) ();

  localparam int LW = led_pattern_pkg::idx_w(NB_LEDS);

  logic                  driver_ready;
  logic                  column_ready;
  logic [LW-1:0]         led_idx;
  logic [NB_DRIVERS-1:0] framebuffer_dat;
  logic [NB_MUX-1:0]     mux_out;
  logic                  position_sync;

  modport master (
    input  driver_ready,
    input  column_ready,
    input  led_idx,
    output framebuffer_dat,
    output mux_out,
    output position_sync
  );

  modport slave (
    output driver_ready,
    output column_ready,
    output led_idx,
    input  framebuffer_dat,
    input  mux_out,
    input  position_sync
  );

endinterface

// File: rtl/led_walk_counter.sv
// Cascaded led/driver/row walk position counter.
// led is the fastest digit; row-only stepping is used by WALK_ROW.
module led_walk_counter
  import led_pattern_pkg::*;
#(
  parameter int NB_LEDS    = NB_LEDS_DEF,
  parameter int NB_DRIVERS = NB_DRIVERS_DEF,
  parameter int NB_MUX     = NB_MUX_DEF,
  localparam int LW = idx_w(NB_LEDS),
  localparam int DW = idx_w(NB_DRIVERS),
  localparam int RW = idx_w(NB_MUX)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          step_all,
  input  logic          step_row,
  output logic [LW-1:0] walk_led,
  output logic [DW-1:0] walk_drv,
  output logic [RW-1:0] walk_row,
  output logic          wrap
);

  logic [LW-1:0] led_q, led_d;
  logic [DW-1:0] drv_q, drv_d;
  logic [RW-1:0] row_q, row_d;
  logic          led_max, drv_max, row_max;

  // Next walk position; wrap flags a return to the origin.
  always_comb begin
    led_max = led_q == LW'(NB_LEDS - 1);
    drv_max = drv_q == DW'(NB_DRIVERS - 1);
    row_max = row_q == RW'(NB_MUX - 1);
    led_d   = led_q;
    drv_d   = drv_q;
    row_d   = row_q;
    wrap    = 1'b0;
    unique case (1'b1)
      clr: begin
        led_d = '0;
        drv_d = '0;
        row_d = '0;
      end
      step_all: begin
        led_d = led_max ? '0 : led_q + LW'(1);
        if (led_max)
          drv_d = drv_max ? '0 : drv_q + DW'(1);
        if (led_max && drv_max)
          row_d = row_max ? '0 : row_q + RW'(1);
        wrap = led_max && drv_max && row_max;
      end
      step_row: begin
        row_d = row_max ? '0 : row_q + RW'(1);
        wrap  = row_max;
      end
      default: ;
    endcase
  end

  // Walk position registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led_q <= '0;
      drv_q <= '0;
      row_q <= '0;
    end else begin
      led_q <= led_d;
      drv_q <= drv_d;
      row_q <= row_d;
    end
  end

  assign walk_led = led_q;
  assign walk_drv = drv_q;
  assign walk_row = row_q;

endmodule

// File: rtl/led_pattern_gen.sv
// Test-pattern source for the LED driver chain.
// Row scan, frame count, mode latch and per-LED pixel function.
module led_pattern_gen
  import led_pattern_pkg::*;
#(
  parameter int NB_DRIVERS  = NB_DRIVERS_DEF,
  parameter int NB_MUX      = NB_MUX_DEF,
  parameter int NB_LEDS     = NB_LEDS_DEF,
  parameter int STEP_FRAMES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        mode,
  input  logic              enable,
  output logic              step_wrap,
  led_pattern_gen_if.master bus
);

  localparam int LW = idx_w(NB_LEDS);
  localparam int DW = idx_w(NB_DRIVERS);
  localparam int RW = idx_w(NB_MUX);
  localparam int FW = idx_w(STEP_FRAMES);
  localparam logic [NB_MUX-1:0] MUX_ROW0 =
    NB_MUX'(1) << (NB_MUX - 1);

  logic [RW-1:0]         row_q, row_d;
  logic [NB_MUX-1:0]     mux_q, mux_d;
  logic [FW-1:0]         frame_q, frame_d;
  pattern_mode_e         active_q, active_d;
  logic                  phase_q, phase_d;
  logic                  ps_q, ps_d;
  logic                  sw_q, sw_d;
  logic [NB_DRIVERS-1:0] fb_q, fb_d;

  logic          adv, row_wrap, step, mode_chg;
  logic          step_all, step_row, walk_wrap;
  logic [LW-1:0] walk_led;
  logic [DW-1:0] walk_drv;
  logic [RW-1:0] walk_row;
  logic          led_hit, row_hit;
  logic [31:0]   led_w;

  // Row scan, frame count, mode latch and pulse generation.
  always_comb begin
    adv      = bus.column_ready & bus.driver_ready & enable;
    row_wrap = adv && (row_q == RW'(NB_MUX - 1));
    step     = row_wrap && (frame_q == FW'(STEP_FRAMES - 1));
    mode_chg = step && (pattern_mode_e'(mode) != active_q);
    step_all = step && !mode_chg && (active_q == WALK_LED);
    step_row = step && !mode_chg && (active_q == WALK_ROW);
    row_d    = row_q;
    mux_d    = mux_q;
    frame_d  = frame_q;
    active_d = active_q;
    phase_d  = phase_q;
    if (adv) begin
      row_d = row_wrap ? '0 : row_q + RW'(1);
      mux_d = row_wrap ? MUX_ROW0 : (mux_q >> 1);
    end
    if (row_wrap)
      frame_d = step ? '0 : frame_q + FW'(1);
    if (step)
      active_d = pattern_mode_e'(mode);
    if (mode_chg)
      phase_d = 1'b0;
    else if (step && active_q == CHECKER)
      phase_d = ~phase_q;
    ps_d = row_wrap;
    sw_d = walk_wrap;
  end

  // Pixel bit per driver for the LED being shifted.
  always_comb begin
    fb_d    = '0;
    led_w   = 32'(bus.led_idx);
    led_hit = bus.led_idx == walk_led;
    row_hit = row_q == walk_row;
    for (int d = 0; d < NB_DRIVERS; d++) begin
      unique case (active_q)
        ALL_ON:   fb_d[d] = 1'b1;
        WALK_LED: fb_d[d] = led_hit && row_hit &&
                            (walk_drv == DW'(d));
        WALK_ROW: fb_d[d] = row_hit;
        CHECKER:  fb_d[d] = bus.led_idx[0] ^ row_q[0] ^
                            phase_q ^ d[0];
        default:  fb_d[d] = 1'b0;
      endcase
    end
    if (!enable || led_w >= 32'(NB_LEDS))
      fb_d = '0;
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_q    <= '0;
      mux_q    <= MUX_ROW0;
      frame_q  <= '0;
      active_q <= ALL_ON;
      phase_q  <= 1'b0;
      ps_q     <= 1'b0;
      sw_q     <= 1'b0;
      fb_q     <= '0;
    end else begin
      row_q    <= row_d;
      mux_q    <= mux_d;
      frame_q  <= frame_d;
      active_q <= active_d;
      phase_q  <= phase_d;
      ps_q     <= ps_d;
      sw_q     <= sw_d;
      fb_q     <= fb_d;
    end
  end

  led_walk_counter #(
    .NB_LEDS    (NB_LEDS),
    .NB_DRIVERS (NB_DRIVERS),
    .NB_MUX     (NB_MUX)
  ) u_walk (
    .clk      (clk),
    .rst      (rst),
    .clr      (mode_chg),
    .step_all (step_all),
    .step_row (step_row),
    .walk_led (walk_led),
    .walk_drv (walk_drv),
    .walk_row (walk_row),
    .wrap     (walk_wrap)
  );

  assign bus.framebuffer_dat = fb_q;
  assign bus.mux_out         = mux_q;
  assign bus.position_sync   = ps_q;
  assign step_wrap           = sw_q;

endmodule

// File: doc/led_pattern_gen.md
Name: led_pattern_gen

Overview:
- Parametrised test-pattern source for the LED driver chain. Replaces the constant all-ones framebuffer, fixed multiplexer word and tied-high position_sync used in single-LED bring-up.
- Sits between the board top and driver_controller. It sources framebuffer_dat, the one-hot multiplexer row select and position_sync, and advances in step with the controller's column_ready.
- Modes: all-on, walking single LED, walking row, and a toggling checkerboard. Each LED, row and driver can be exercised individually on the rotating display.

Parameters:
- NB_DRIVERS, 30: number of serial driver chains; width of framebuffer_dat.
- NB_MUX, 8: number of multiplexed rows; width of mux_out.
- NB_LEDS, 16: LEDs per driver per row; range of led_idx.
- STEP_FRAMES, 4: complete mux scans per pattern step. Minimum 1.

Ports:
- clk, in, 1: system clock.
- rst, in, 1: asynchronous active-high reset.
- mode, in, 2: 0 ALL_ON, 1 WALK_LED, 2 WALK_ROW, 3 CHECKER.
- enable, in, 1: pattern enable.
- driver_ready, in, 1: driver configuration complete. Counters frozen while low.
- column_ready, in, 1: one-cycle pulse from driver_controller at the end of each column shift.
- led_idx, in, $clog2(NB_LEDS): LED currently being shifted by driver_controller.
- framebuffer_dat, out, NB_DRIVERS: per-driver on/off bit for led_idx in the current row.
- mux_out, out, NB_MUX: one-hot row select.
- position_sync, out, 1: one-cycle pulse at each return to row 0.
- step_wrap, out, 1: one-cycle pulse when the walk position wraps to its origin.

Behaviour:
- Reset, asynchronous on rst:
  - framebuffer_dat = 0.
  - mux_out = 1 << (NB_MUX-1), i.e. row 0 is the MSB, matching the bring-up word 8'b10000000.
  - position_sync = 0, step_wrap = 0.
  - All counters = 0.
  - active_mode = ALL_ON, phase = 0.
- Advance condition: adv = column_ready & driver_ready & enable. No counter or mux movement occurs otherwise.
- Row scan:
  - On adv, row_idx increments and mux_out rotates right one bit.
  - From NB_MUX-1, row_idx wraps to 0 and mux_out wraps back to the MSB.
  - position_sync pulses the cycle after the wrap, registered.
- Frame counter:
  - Increments on each row wrap.
  - At STEP_FRAMES-1 it wraps to 0 and produces a step event in the same cycle.
- Walk position, updated on a step event:
  - Tuple (walk_led, walk_drv, walk_row), with walk_led fastest.
  - WALK_LED steps through all NB_LEDS*NB_DRIVERS*NB_MUX positions.
  - WALK_ROW steps walk_row only.
  - CHECKER toggles phase.
  - ALL_ON holds.
  - step_wrap pulses the cycle after the tuple returns to (0,0,0), or after walk_row returns to 0 in WALK_ROW.
- Mode latching:
  - The mode input is sampled into active_mode only on a step event.
  - If the sampled value differs from active_mode, the walk tuple and phase are cleared to 0 in that same cycle instead of advancing, and step_wrap does not pulse.
- Pixel function, evaluated combinationally from registered state plus led_idx and registered to framebuffer_dat (1-cycle latency from led_idx):
  - ALL_ON: bit d = 1.
  - WALK_LED: d == walk_drv && led_idx == walk_led && row_idx == walk_row.
  - WALK_ROW: row_idx == walk_row.
  - CHECKER: parity(d + led_idx + row_idx + phase) == 1.
- enable low: framebuffer_dat = 0 on the next cycle. mux_out keeps its current value and counters hold.
- Boundary conditions:
  - led_idx >= NB_LEDS: framebuffer_dat = 0.
  - column_ready while driver_ready = 0: ignored.
  - A row wrap, frame wrap and walk wrap coinciding in one adv cycle are all applied in that single cycle.
  - rst mid-pattern: immediate return to the reset state, with no partial pulses.

Decomposition:
- Package led_pattern_pkg:
  - pattern_mode_e enum: ALL_ON, WALK_LED, WALK_ROW, CHECKER.
  - Default constants NB_DRIVERS_DEF = 30, NB_MUX_DEF = 8, NB_LEDS_DEF = 16.
- Sub-module led_walk_counter: the cascaded led/driver/row walk counter with clear, step and wrap output. The parent keeps the row scan, frame counter, mode latch and pixel function.

Test Plan:
Bench parameters NB_DRIVERS = 4, NB_MUX = 4, NB_LEDS = 4, STEP_FRAMES = 2.
- Reset then idle: mux_out = 4'b1000, framebuffer_dat = 0. With enable = 1 and mode = 0, after one step framebuffer_dat = 4'b1111 for every led_idx.
- driver_ready = 0 with 10 column_ready pulses: mux_out stays 4'b1000. Set driver_ready = 1 and give 4 pulses: mux_out reads 0100, 0010, 0001, 1000, and position_sync pulses once after the 4th.
- mode = 1 latched at the first step: with row 0 and led_idx = 0, framebuffer_dat = 4'b0001. After 2 further scans (one step), led_idx = 1 gives 4'b0001 and led_idx = 0 gives 0. step_wrap pulses after 64 steps.
- mode = 2: framebuffer_dat = 4'b1111 only while mux_out = 1000, and 0 on the other rows. After one step it is 1111 only while mux_out = 0100.
- mode changed from 1 to 3 mid-walk: no effect until the next step event. Then phase = 0, and row 0 with led_idx = 0 gives framebuffer_dat = 4'b1010.
- rst asserted between column_ready pulses, mid-walk: all outputs return to reset values in the same cycle, and no position_sync or step_wrap pulse is emitted.
